// File: rtl/fsm.sv
// Vending machine control FSM. It watches the running credit and the front-panel
// buttons, then drives the panel indicators. The state and all outputs are registered.
module fsm #(
    parameter int PRICE_ONE = 5,
    parameter int PRICE_TWO = 10,
    parameter int VAL_W     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cancle_flag,
    input  logic [VAL_W-1:0] coin_val,
    input  logic             get_ind,
    input  logic             buy_flag,
    output logic             op_start,
    output logic             light,
    output logic             light_one,
    output logic             light_two,
    output logic             hold_ind,
    output logic             not_enough
);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_READY  = 3'd1,
        ST_COIN   = 3'd2,
        ST_BUY    = 3'd3,
        ST_RETURN = 3'd4
    } state_t;

    // Prices are brought to the width of coin_val. The thresholds then compare unsigned at full width.
    localparam logic [VAL_W-1:0] P_ONE = PRICE_ONE[VAL_W-1:0];
    localparam logic [VAL_W-1:0] P_TWO = PRICE_TWO[VAL_W-1:0];

    state_t r_state;
    state_t w_next;

    logic r_op_start;
    logic r_light;
    logic r_light_one;
    logic r_light_two;
    logic r_hold_ind;
    logic r_not_enough;

    logic w_close;
    logic w_credit;
    logic w_ge_one;
    logic w_ge_two;
    logic w_op_start;
    logic w_light;
    logic w_light_one;
    logic w_light_two;
    logic w_hold_ind;
    logic w_not_enough;

    assign w_close  = cancle_flag | get_ind;
    assign w_credit = |coin_val;
    assign w_ge_one = (coin_val >= P_ONE);
    assign w_ge_two = (coin_val >= P_TWO);

    // Next state: a close request (cancel or collect) wins, then buy, then credit.
    always_comb begin
        // NOTE: a default is assigned before the case. Every path then assigns w_next, so no latch is inferred.
        w_next = ST_READY;
        unique case (r_state)
            ST_OFF:    w_next = ST_READY;
            ST_READY: begin
                if (w_close)       w_next = ST_READY;
                else if (buy_flag) w_next = ST_BUY;
                else if (w_credit) w_next = ST_COIN;
                else               w_next = ST_READY;
            end
            ST_COIN: begin
                if (w_close)        w_next = ST_RETURN;
                else if (buy_flag)  w_next = ST_BUY;
                else if (!w_credit) w_next = ST_READY;
                else                w_next = ST_COIN;
            end
            ST_BUY: begin
                if (w_close)        w_next = ST_RETURN;
                else if (!buy_flag) w_next = w_credit ? ST_COIN : ST_READY;
                else                w_next = ST_BUY;
            end
            ST_RETURN: begin
                if (!w_close && !w_credit) w_next = ST_READY;
                else                       w_next = ST_RETURN;
            end
            default:   w_next = ST_READY;
        endcase
    end

    // Output decode uses the next state and the coin_val sampled now, so the registered outputs track the same edge.
    always_comb begin
        w_op_start   = (w_next != ST_OFF);
        w_light      = 1'b0;
        w_light_one  = 1'b0;
        w_light_two  = 1'b0;
        w_hold_ind   = (w_next == ST_RETURN);
        w_not_enough = 1'b0;
        if (w_next == ST_COIN || w_next == ST_BUY) begin
            w_light     = w_credit;
            w_light_one = w_ge_one;
            w_light_two = w_ge_two;
        end
        if (w_next == ST_BUY) begin
            w_not_enough = !w_ge_one;
        end
    end

    // State and output registers. Reset low forces OFF and clears every indicator at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_OFF;
            r_op_start   <= 1'b0;
            r_light      <= 1'b0;
            r_light_one  <= 1'b0;
            r_light_two  <= 1'b0;
            r_hold_ind   <= 1'b0;
            r_not_enough <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments are used here. Every register updates from values sampled before the edge.
            r_state      <= w_next;
            r_op_start   <= w_op_start;
            r_light      <= w_light;
            r_light_one  <= w_light_one;
            r_light_two  <= w_light_two;
            r_hold_ind   <= w_hold_ind;
            r_not_enough <= w_not_enough;
        end
    end

    assign op_start   = r_op_start;
    assign light      = r_light;
    assign light_one  = r_light_one;
    assign light_two  = r_light_two;
    assign hold_ind   = r_hold_ind;
    assign not_enough = r_not_enough;

endmodule

// File: tb/tb_fsm.sv
// Testbench for the vending machine FSM. The stimulus pushes expected panel outputs into a scoreboard queue.
// A separate monitor pops each entry and compares it after a clock edge, or right after an asynchronous reset.
module tb_fsm;

    localparam int PRICE_ONE = 5;
    localparam int PRICE_TWO = 10;
    localparam int VAL_W     = 10;

    // Machine modes as seen from the panel.
    localparam int M_OFF = 0, M_READY = 1, M_COIN = 2, M_BUY = 3, M_RET = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cancle_flag = 1'b0;
    logic [VAL_W-1:0] coin_val = '0;
    logic             get_ind = 1'b0;
    logic             buy_flag = 1'b0;
    logic             op_start, light, light_one, light_two, hold_ind, not_enough;

    fsm #(.PRICE_ONE(PRICE_ONE), .PRICE_TWO(PRICE_TWO), .VAL_W(VAL_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cancle_flag (cancle_flag),
        .coin_val    (coin_val),
        .get_ind     (get_ind),
        .buy_flag    (buy_flag),
        .op_start    (op_start),
        .light       (light),
        .light_one   (light_one),
        .light_two   (light_two),
        .hold_ind    (hold_ind),
        .not_enough  (not_enough)
    );

    always #5 clk = ~clk;

    // Each expected entry is {op_start, light, light_one, light_two, hold_ind, not_enough}.
    logic [5:0] sb_q[$];
    int         n_vec  = 0;
    int         n_miss = 0;
    int         mode   = M_OFF;
    event       ev_async;

    // The reference model works from the vending rules: a close request ends an active transaction.
    // A buy request takes priority over credit tracking.
    function automatic int model_next(int m, bit b, bit c, bit g, int credit);
        bit close_req = c || g;
        case (m)
            M_OFF:   return M_READY;
            M_READY: return close_req ? M_READY : b ? M_BUY : (credit > 0) ? M_COIN : M_READY;
            M_COIN:  return close_req ? M_RET : b ? M_BUY : (credit == 0) ? M_READY : M_COIN;
            M_BUY:   return close_req ? M_RET : b ? M_BUY : (credit > 0) ? M_COIN : M_READY;
            default: return (!close_req && credit == 0) ? M_READY : M_RET;
        endcase
    endfunction

    function automatic logic [5:0] model_out(int m, int credit);
        bit active = (m == M_COIN) || (m == M_BUY);
        if (m == M_OFF) return 6'b0;
        return {1'b1,
                active && credit > 0,
                active && credit >= PRICE_ONE,
                active && credit >= PRICE_TWO,
                m == M_RET,
                m == M_BUY && credit < PRICE_ONE};
    endfunction

    // One cycle of stimulus: drive at the falling edge, then queue what the next rising edge must show.
    task automatic step(input bit rst, input int credit, input bit b, input bit c, input bit g);
        @(negedge clk);
        reset       = rst;
        coin_val    = credit[VAL_W-1:0];
        buy_flag    = b;
        cancle_flag = c;
        get_ind     = g;
        if (!rst) mode = M_OFF;
        else      mode = model_next(mode, b, c, g, credit);
        sb_q.push_back(model_out(mode, credit));
    endtask

    // Pull reset low between edges. Outputs must clear at once, and they stay clear through the next edge.
    task automatic async_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        mode  = M_OFF;
        sb_q.push_back(6'b0);
        -> ev_async;
        #2;
        sb_q.push_back(6'b0);
    endtask

    // Monitor: compare the DUT outputs against the oldest expectation, away from the active edge.
    initial begin
        logic [5:0] exp_v;
        logic [5:0] act_v;
        forever begin
            @(posedge clk or ev_async);
            #1;
            if (sb_q.size() > 0) begin
                exp_v = sb_q.pop_front();
                act_v = {op_start, light, light_one, light_two, hold_ind, not_enough};
                n_vec++;
                if (act_v !== exp_v) begin
                    n_miss++;
                    $display("FAIL outputs t=%0t coin=%0d buy=%b cancel=%b get=%b rst=%b: got op/l/l1/l2/hold/ne=%b expected %b",
                             $time, coin_val, buy_flag, cancle_flag, get_ind, reset, act_v, exp_v);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int credit;
        // Power-up: reset held low, then released with no credit.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Credit ramp.
        begin
            int ramp[4] = '{2, 4, 6, 26};
            foreach (ramp[i]) begin
                step(1, ramp[i], 0, 0, 0);
                step(1, ramp[i], 0, 0, 0);
            end
        end
        // Purchases, then collect.
        step(1, 16, 1, 0, 0);
        step(1, 11, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        // Cancel.
        step(1, 2, 0, 0, 0);
        step(1, 4, 0, 0, 0);
        step(1, 6, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        // Reset mid-operation.
        step(1, 20, 0, 0, 0);
        async_reset();
        step(1, 0, 0, 0, 0);
        // Buy and cancel together while holding credit.
        step(1, 8, 0, 0, 0);
        step(1, 8, 1, 1, 0);
        step(1, 0, 0, 0, 0);
        // Large credit at full width, plus a close request held with credit still present.
        step(1, 1023, 1, 0, 0);
        step(1, 1023, 0, 1, 1);
        step(1, 3, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0:       credit = 0;
                1:       credit = $urandom_range(0, (1 << VAL_W) - 1);
                default: credit = $urandom_range(0, 30);
            endcase
            if ($urandom_range(0, 99) < 2) begin
                async_reset();
            end else begin
                step($urandom_range(0, 99) >= 3, credit,
                     $urandom_range(0, 99) < 35,
                     $urandom_range(0, 99) < 10,
                     $urandom_range(0, 99) < 10);
            end
        end
        @(posedge clk);
        #3;
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
